// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: data word width, width of
// the wait-state counter, and the responder FSM state encoding.
// No ports (package). Optional feature macro used elsewhere: DMEM_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_W = 32;   // data and address width
    localparam int CNT_W  = 4;    // wait counter, covers WAIT_CYCLES 0..15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage : dmem_pkg

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// Processor <-> data-memory handshake bundle.
//   master (processor): drives req_valid/req_we/req_addr/req_wdata,
//                       receives req_ready/resp_valid/resp_rdata/resp_err/stall.
//   slave  (responder): the mirror image.
// -----------------------------------------------------------------------------
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;
    logic              stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );

endinterface : dmem_if

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x WORD_W word storage: synchronous write, combinational read.
// Ports:
//   clk    - clock
//   we     - write enable, word written on the rising edge
//   waddr  - write word index
//   wdata  - write data
//   raddr  - read word index
//   rdata  - read data (combinational)
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset on purpose -- contents must survive rst, and a
    // reset would prevent mapping onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : dmem_array

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Word-addressed data memory with a fixed number of wait states, answering a
// processor load/store interface. IDLE accepts, WAIT counts WAIT_CYCLES, RESP
// pulses resp_valid for one cycle; the array is written/read on the edge that
// enters RESP. Out-of-range word indices respond with resp_err and no write.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous, active-high reset (array contents kept)
//   bus  - dmem_if.slave: req_valid/req_we/req_addr/req_wdata in,
//          req_ready/resp_valid/resp_rdata/resp_err/stall out
// Optional feature: define DMEM_ALIGN_CHECK_EN to also reject addresses with
// addr[1:0] != 0 (same latency, resp_err=1, no write).
// -----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    logic              acc_we;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_err;
    logic              enter_resp;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    // The access completing this cycle: with zero wait states it completes
    // straight out of IDLE, before the request has been latched, so IDLE
    // looks at the bus and every other state at the latched copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        acc_err = ({2'b00, acc_addr[WORD_W-1:2]} >= WORD_W'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
        acc_err = acc_err | (acc_addr[1:0] != 2'b00);
`endif
    end

`ifndef DMEM_ALIGN_CHECK_EN
    // Byte offset is meaningless for word accesses when alignment is not checked.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^acc_addr[1:0];
`endif

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        rdata_d      = rdata_q;
        enter_resp   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        cnt_d      = '0;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            resp_valid_d = 1'b1;
            resp_err_d   = acc_err;
            rdata_d      = (acc_we || acc_err) ? '0 : mem_rdata;
        end
    end

    // Reset must also block the write, so an access interrupted on its last
    // wait cycle leaves the array untouched.
    assign mem_we = enter_resp & acc_we & ~acc_err & ~rst;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .raddr (acc_addr[AW+1:2]),
        .rdata (mem_rdata)
    );

    // NOTE: non-blocking assignments so all flops sample the pre-edge values
    // and the simulation order of always_ff blocks cannot matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.stall      = (state_q == ST_WAIT) | ((state_q == ST_IDLE) & bus.req_valid);

endmodule : data_mem_responder

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states between acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  processor presents a data-memory access.
REQ-006 SHALL have port req_we  input  1  1 = store word, 0 = load word.
REQ-007 SHALL have port req_addr  input  32  byte address, i.e. processor ALU_out.
REQ-008 SHALL have port req_wdata  input  32  store data, i.e. processor mem_data_w.
REQ-009 SHALL have port req_ready  output  1  request accepted this cycle.
REQ-010 SHALL have port resp_valid  output  1  one-cycle pulse, access complete.
REQ-011 SHALL have port resp_rdata  output  32  load data, i.e. processor mem_data_r; valid with resp_valid.
REQ-012 SHALL have port resp_err  output  1  access rejected; valid with resp_valid.
REQ-013 SHALL have port stall  output  1  processor must hold PC and register writes.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 IDLE: req_ready=1; req_valid=1 SHALL latch we/addr/wdata, load wait counter with WAIT_CYCLES, go to WAIT (or directly to RESP if WAIT_CYCLES=0).
REQ-016 WAIT: counter SHALL decrement each cycle; transition to RESP when counter reaches 1 (decrement to 0).
REQ-017 On the cycle entering RESP, a valid store SHALL write the word array; a valid load SHALL register array[addr[31:2]] into resp_rdata.
REQ-018 RESP: resp_valid=1 for exactly one cycle, req_ready=0, then SHALL return to IDLE unconditionally.
REQ-019 Latency SHALL be exactly WAIT_CYCLES+1 cycles from acceptance edge to resp_valid high.
REQ-020 stall SHALL equal (state==WAIT) | (state==IDLE & req_valid) | (state==RESP & 0), i.e. low in RESP.
REQ-021 req_valid outside IDLE SHALL be ignored; new request accepted no earlier than the cycle after RESP.
REQ-022 Word index addr[31:2] >= DEPTH SHALL produce resp_err=1, resp_rdata=0, and no array write.
REQ-023 resp_rdata SHALL be 0 for stores and hold its value between responses.
REQ-024 Store followed by load to same address SHALL return the newly stored word.

Reset
REQ-025 rst SHALL force state IDLE, counter 0, resp_valid=0, resp_err=0, resp_rdata=0, latched request cleared.
REQ-026 rst asserted in WAIT SHALL abandon the access: no array write, no resp_valid.
REQ-027 Array contents SHALL NOT be cleared by rst.
REQ-028 After rst deasserts, req_ready SHALL be 1 in the first cycle.

Configuration
REQ-029 Macro DMEM_ALIGN_CHECK_EN defined: addr[1:0] != 0 SHALL give resp_err=1, resp_rdata=0, no write, same latency.
REQ-030 Macro DMEM_ALIGN_CHECK_EN undefined: addr[1:0] SHALL be ignored; only the range check applies.

Structure
REQ-031 Package dmem_pkg SHALL hold the FSM state enum, WORD_W=32, and wait-counter width constant.
REQ-032 Word storage SHALL be one sub-module dmem_array (synchronous write, combinational read, DEPTH words); FSM and checks stay in data_mem_responder.

Verification
REQ-033 Reset: rst=1 for 2 cycles, then 0 -> req_ready=1, resp_valid=0, resp_rdata=0, stall=0.
REQ-034 Store addr 0x10, data 0xDEADBEEF, then load 0x10, WAIT_CYCLES=2 -> resp_valid 3 cycles after each acceptance; load rdata=0xDEADBEEF, err=0.
REQ-035 Load addr 0x100 with DEPTH=64 -> resp_err=1, rdata=0; array word 0 unchanged.
REQ-036 DMEM_ALIGN_CHECK_EN defined, store addr 0x12 -> resp_err=1, no write; undefined -> writes word 4, err=0.
REQ-037 Store accepted, rst pulsed in WAIT -> no resp_valid; subsequent load of that address returns prior contents.
REQ-038 WAIT_CYCLES=0, back-to-back req_valid held high -> resp_valid every 2nd cycle, stall low only in RESP cycles.
